framebuffer_write_arbiter: RTL

// - Owns the write port of the pixel dual-port RAM and shares it between two requesters.
// - Requester 1: host pixel writes from the MCU bus interface, using a valid/ready handshake.
// - Requester 2: an internal fill engine that writes one colour over a contiguous address range (clear screen, rectangle fill).
// - Drives the RAM write_address, data and write_enable directly. Runs on the write-side clock; the read/scan-out side is untouched.
//

---
 rtl/framebuffer_write_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/framebuffer_write_arbiter.sv
// ---------------------------------------------------------------------------
// framebuffer_write_arbiter
//
// Owns the write port of the pixel dual-port RAM and shares it between two
// requesters: host pixel writes arriving over a valid/ready handshake, and an
// internal fill engine that paints one colour over a contiguous, wrapping
// address range (clear screen, rectangle fill). Every granted write appears
// on the registered o_write_* outputs one cycle after its grant; at most one
// write is issued per cycle. The read/scan-out side of the RAM is untouched.
//
// Configuration macro: ARBITER_ROUND_ROBIN_EN
//   undefined : fixed priority, the host always wins a tie (a fill may stall
//               for as long as the host keeps i_host_valid high)
//   defined   : round robin on ties, the requester that lost the previous tie
//               wins the next one; uncontended grants leave the history alone
//
// Parameters
//   DATA_WIDTH    pixel width, must match the RAM data width
//   ADDRESS_SIZE  RAM address width; depth is 2**ADDRESS_SIZE words
//
// Ports
//   i_clock          block clock, also clocks the RAM write port
//   i_reset          synchronous, active-high; abandons a running fill
//   i_host_valid     host write request pending
//   o_host_ready     host request granted this cycle (combinational)
//   i_host_address   host write address, held stable until transfer
//   i_host_data      host pixel value, held stable until transfer
//   i_fill_start     single-cycle pulse starting a fill (ignored while busy)
//   i_fill_base      first fill address, sampled on i_fill_start
//   i_fill_length    word count 0..2**ADDRESS_SIZE, sampled on i_fill_start
//   i_fill_color     fill value, sampled on i_fill_start
//   o_fill_busy      a fill is in progress
//   o_fill_done      single-cycle completion pulse
//   o_write_enable   RAM write enable
//   o_write_address  RAM write address
//   o_data           RAM write data
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module framebuffer_write_arbiter #(
    parameter int DATA_WIDTH   = 12,
    parameter int ADDRESS_SIZE = 13
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_host_valid,
    output logic                    o_host_ready,
    input  logic [ADDRESS_SIZE-1:0] i_host_address,
    input  logic [DATA_WIDTH-1:0]   i_host_data,
    input  logic                    i_fill_start,
    input  logic [ADDRESS_SIZE-1:0] i_fill_base,
    input  logic [ADDRESS_SIZE:0]   i_fill_length,
    input  logic [DATA_WIDTH-1:0]   i_fill_color,
    output logic                    o_fill_busy,
    output logic                    o_fill_done,
    output logic                    o_write_enable,
    output logic [ADDRESS_SIZE-1:0] o_write_address,
    output logic [DATA_WIDTH-1:0]   o_data
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FILL = 1'b1;

    localparam logic [ADDRESS_SIZE-1:0] ADDR_ONE = {{(ADDRESS_SIZE-1){1'b0}}, 1'b1};
    localparam logic [ADDRESS_SIZE:0]   LEN_ZERO = '0;
    localparam logic [ADDRESS_SIZE:0]   LEN_ONE  = {{ADDRESS_SIZE{1'b0}}, 1'b1};

    logic [0:0]              r_state;
    logic [ADDRESS_SIZE-1:0] r_fill_base;
    logic [ADDRESS_SIZE-1:0] r_fill_offset;
    logic [ADDRESS_SIZE:0]   r_fill_remaining;   // one bit wider: a full-memory fill is 2**ADDRESS_SIZE words
    logic [DATA_WIDTH-1:0]   r_fill_color;
    logic                    r_fill_done;
    logic                    r_write_enable;
    logic [ADDRESS_SIZE-1:0] r_write_address;
    logic [DATA_WIDTH-1:0]   r_data;

    logic                    w_fill_request;
    logic                    w_grant_host;
    logic                    w_grant_fill;
    logic                    w_fill_last;
    logic [ADDRESS_SIZE-1:0] w_fill_address;

    assign w_fill_request = (r_state == S_FILL);
    // The sum is truncated to ADDRESS_SIZE bits, which gives the modulo wrap.
    assign w_fill_address = r_fill_base + r_fill_offset;
    assign w_fill_last    = (r_fill_remaining == LEN_ONE);

`ifdef ARBITER_ROUND_ROBIN_EN
    localparam logic GRANT_HOST = 1'b0;
    localparam logic GRANT_FILL = 1'b1;

    logic r_last_grant;
    logic w_tie;

    assign w_tie = i_host_valid && w_fill_request;
    // On a tie the host wins only if the fill took the previous tie.
    assign w_grant_host = i_host_valid && (!w_fill_request || (r_last_grant == GRANT_FILL));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            // Fill history at reset so that the host wins the first tie.
            r_last_grant <= GRANT_FILL;
        end else if (w_tie) begin
            // Uncontended grants deliberately leave the history unchanged.
            r_last_grant <= w_grant_host ? GRANT_HOST : GRANT_FILL;
        end
    end
`else
    // Fixed priority: a pending host request always takes the port.
    assign w_grant_host = i_host_valid;
`endif

    assign w_grant_fill = w_fill_request && !w_grant_host;
    assign o_host_ready = w_grant_host;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others; blocking here would create ordering races.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state          <= S_IDLE;
            r_fill_base      <= '0;
            r_fill_offset    <= '0;
            r_fill_remaining <= '0;
            r_fill_color     <= '0;
            r_fill_done      <= 1'b0;
            r_write_enable   <= 1'b0;
            r_write_address  <= '0;
            r_data           <= '0;
        end else begin
            r_write_enable <= w_grant_host || w_grant_fill;
            r_fill_done    <= 1'b0;

            // Address/data hold their last value when nothing is granted;
            // the RAM ignores them while write_enable is low.
            if (w_grant_host) begin
                r_write_address <= i_host_address;
                r_data          <= i_host_data;
            end else if (w_grant_fill) begin
                r_write_address <= w_fill_address;
                r_data          <= r_fill_color;
            end

            if (r_state == S_IDLE) begin
                if (i_fill_start) begin
                    if (i_fill_length == LEN_ZERO) begin
                        // Empty fill: nothing to write, just report completion.
                        r_fill_done <= 1'b1;
                    end else begin
                        r_fill_base      <= i_fill_base;
                        r_fill_color     <= i_fill_color;
                        r_fill_remaining <= i_fill_length;
                        r_fill_offset    <= '0;
                        r_state          <= S_FILL;
                    end
                end
            end else begin
                // A fill_start arriving here is ignored; the running fill continues.
                if (w_grant_fill) begin
                    r_fill_offset    <= r_fill_offset + ADDR_ONE;
                    r_fill_remaining <= r_fill_remaining - LEN_ONE;
                    if (w_fill_last) begin
                        // Done lines up with the last write on the outputs.
                        r_fill_done <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
            end
        end
    end

    // Busy is the registered FILL state: it rises the cycle after fill_start and
    // falls in the same cycle the last fill write appears with fill_done.
    assign o_fill_busy     = (r_state == S_FILL);
    assign o_fill_done     = r_fill_done;
    assign o_write_enable  = r_write_enable;
    assign o_write_address = r_write_address;
    assign o_data          = r_data;

endmodule
